pwm_duty_ramp_ctrl: RTL and testbench

//  Duty-cycle controller for a free-running M-step PWM counter that drives a `data` input and emits a period-end pulse `co`.
//  - Accepts target duties over a valid/ready handshake.
//  - Ramps the applied duty toward the target in programmable steps.
//  - Changes duty only on period boundaries, so the PWM never sees a mid-period glitch.
//  - Sits between the register/firmware side and the PWM datapath.

---
 rtl/pwm_duty_ramp_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_duty_ramp_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_duty_ramp_ctrl
// Duty-cycle controller for a free-running M-step PWM counter. Takes a target
// duty over valid/ready, then walks the applied duty toward it in programmable
// steps. The duty only changes in a cycle where co=1, so the PWM picks up each
// new value from cnt=0 and never sees a glitch in the middle of a period.
//
// Optional feature macro: PWM_DUTY_SOFTSTOP_EN
//   defined   : dropping en ramps the duty down to 0 (STOP state) with the
//               latched step/div before the controller returns to IDLE.
//   undefined : dropping en zeroes the duty at the next co and returns to IDLE.
// -----------------------------------------------------------------------------
module pwm_duty_ramp_ctrl #(
  parameter int M     = 256,
  parameter int DW    = $clog2(M),
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [DW-1:0]    tgt_duty,
  input  logic [DW-1:0]    step,
  input  logic [DIV_W-1:0] div,
  input  logic             co,
  output logic [DW-1:0]    duty,
  output logic             busy,
  output logic             done
);

  localparam logic [DW-1:0] DUTY_MAX = DW'(M - 1);

`ifdef PWM_DUTY_SOFTSTOP_EN
  typedef enum logic [1:0] {IDLE, RAMP, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, RAMP} state_t;
`endif

  state_t           state;
  logic [DW-1:0]    tgt_q;
  logic [DW-1:0]    step_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] pcnt;
  logic [DW-1:0]    tgt_sat;
  logic [DW-1:0]    ramp_duty;
  logic             upd_due;
`ifdef PWM_DUTY_SOFTSTOP_EN
  logic [DW-1:0]    stop_duty;
`else
  logic             zero_pend;
`endif

  // One ramp update from cur toward tgt: step==0 jumps, upward moves clamp at
  // tgt using a carry bit so the sum cannot wrap, downward moves clamp at tgt.
  function automatic logic [DW-1:0] step_toward(input logic [DW-1:0] cur,
                                                input logic [DW-1:0] tgt,
                                                input logic [DW-1:0] stp);
    logic [DW:0] sum;
    sum = {1'b0, cur} + {1'b0, stp};
    if (stp == '0)
      return tgt;
    if (cur < tgt)
      return (sum > {1'b0, tgt}) ? tgt : sum[DW-1:0];
    if ((cur - tgt) > stp)
      return cur - stp;
    return tgt;
  endfunction

  assign tgt_ready = en && (state == IDLE);
  assign tgt_sat   = (tgt_duty > DUTY_MAX) ? DUTY_MAX : tgt_duty;
  assign ramp_duty = step_toward(duty, tgt_q, step_q);
  // A co only moves the duty once div+1 periods have elapsed since the last move.
  assign upd_due   = co && (pcnt == div_q);
`ifdef PWM_DUTY_SOFTSTOP_EN
  assign stop_duty = step_toward(duty, '0, step_q);
`endif

  // Controller state, period divider and registered outputs.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order in this block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pcnt      <= '0;
      tgt_q     <= '0;
      step_q    <= '0;
      div_q     <= '0;
`ifndef PWM_DUTY_SOFTSTOP_EN
      zero_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
`ifdef PWM_DUTY_SOFTSTOP_EN
      case (state)
        IDLE: begin
          if (!en) begin
            // Only a non-zero duty needs a soft ramp-down.
            if (duty != '0) begin
              state <= STOP;
              busy  <= 1'b1;
              pcnt  <= '0;
            end
          end else if (tgt_valid) begin
            tgt_q  <= tgt_sat;
            step_q <= step;
            div_q  <= div;
            pcnt   <= '0;
            state  <= RAMP;
            busy   <= 1'b1;
          end
        end
        RAMP: begin
          if (!en) begin
            state <= STOP;
            pcnt  <= '0;
          end else if (co) begin
            if (!upd_due) begin
              pcnt <= pcnt + 1'b1;
            end else begin
              pcnt <= '0;
              duty <= ramp_duty;
              if (ramp_duty == tgt_q) begin
                done  <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        STOP: begin
          // The ramp-down always finishes, even if en comes back meanwhile.
          if (co) begin
            if (!upd_due) begin
              pcnt <= pcnt + 1'b1;
            end else begin
              pcnt <= '0;
              duty <= stop_duty;
              if (stop_duty == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
`else
      if (!en) begin
        // Abandon any ramp at once; the duty itself waits for a period boundary.
        state <= IDLE;
        busy  <= 1'b0;
        pcnt  <= '0;
        if (co) begin
          duty      <= '0;
          zero_pend <= 1'b0;
        end else begin
          zero_pend <= 1'b1;
        end
      end else begin
        case (state)
          IDLE: begin
            if (tgt_valid) begin
              // A new request supersedes a zeroing still waiting for its co.
              tgt_q     <= tgt_sat;
              step_q    <= step;
              div_q     <= div;
              pcnt      <= '0;
              state     <= RAMP;
              busy      <= 1'b1;
              zero_pend <= 1'b0;
            end else if (co && zero_pend) begin
              duty      <= '0;
              zero_pend <= 1'b0;
            end
          end
          RAMP: begin
            if (co) begin
              if (!upd_due) begin
                pcnt <= pcnt + 1'b1;
              end else begin
                pcnt <= '0;
                duty <= ramp_duty;
                if (ramp_duty == tgt_q) begin
                  done  <= 1'b1;
                  state <= IDLE;
                  busy  <= 1'b0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
`endif
    end
  end

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_ramp_ctrl
// Directed and randomised bench for pwm_duty_ramp_ctrl at M=16. The bench
// plays the PWM counter itself: co is high for one cycle in every 16. Expected
// duties come from a closed-form model: after n co pulses since acceptance,
// n/(div+1) updates have happened, each moving the duty step counts toward the
// target and clamping there.
// Honours PWM_DUTY_SOFTSTOP_EN for the disable scenario.
// -----------------------------------------------------------------------------
module tb_pwm_duty_ramp_ctrl;

  localparam int M     = 16;
  localparam int DW    = 4;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             tgt_valid;
  logic             tgt_ready;
  logic [DW-1:0]    tgt_duty;
  logic [DW-1:0]    step;
  logic [DIV_W-1:0] div;
  logic             co;
  logic [DW-1:0]    duty;
  logic             busy;
  logic             done;

  int checks     = 0;
  int errors     = 0;
  int cnt        = 0;
  int model_duty = 0;
  bit had_co     = 1'b0;

  pwm_duty_ramp_ctrl #(.M(M), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .tgt_valid (tgt_valid),
    .tgt_ready (tgt_ready),
    .tgt_duty  (tgt_duty),
    .step      (step),
    .div       (div),
    .co        (co),
    .duty      (duty),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: remember whether the DUT saw co at this edge, then advance the
  // bench's PWM counter 1 ns after the edge.
  task automatic tick();
    had_co = co;
    @(posedge clk);
    #1;
    cnt = (cnt + 1) % M;
    co  = (cnt == M - 1);
  endtask

  // Duty expected after n co pulses of a ramp from d0 to t.
  function automatic int ramp_expect(input int d0, input int t, input int s,
                                     input int d, input int n);
    int u;
    u = n / (d + 1);
    if (u == 0) return d0;
    if (s == 0) return t;
    if (t >= d0) return (d0 + u * s < t) ? d0 + u * s : t;
    return (d0 - u * s > t) ? d0 - u * s : t;
  endfunction

  // Number of duty updates needed to land on the target.
  function automatic int updates_needed(input int d0, input int t, input int s);
    int diff;
    if (s == 0 || d0 == t) return 1;
    diff = (t > d0) ? t - d0 : d0 - t;
    return (diff + s - 1) / s;
  endfunction

  task automatic start_request(input int t, input int s, input int d);
    tgt_duty  = DW'(t);
    step      = DW'(s);
    div       = DIV_W'(d);
    tgt_valid = 1'b1;
    check("ready_idle", int'(tgt_ready), 1);
    tick();
    tgt_valid = 1'b0;
    check("busy_after_accept", int'(busy), 1);
    check("ready_after_accept", int'(tgt_ready), 0);
  endtask

  // Observe co pulses of a ramp; stop_after=0 follows it to completion.
  task automatic follow(input int d0, input int t, input int s, input int d,
                        input int stop_after);
    int n_total;
    int lim;
    int n;
    int cyc;
    n_total = updates_needed(d0, t, s) * (d + 1);
    lim     = (stop_after != 0) ? stop_after : n_total;
    n       = 0;
    cyc     = 0;
    while (n < lim && cyc < (lim + 2) * M) begin
      tick();
      cyc++;
      if (had_co) begin
        n++;
        check("duty", int'(duty), ramp_expect(d0, t, s, d, n));
        check("done", int'(done), int'(n == n_total));
        check("busy", int'(busy), int'(n < n_total));
        if (tgt_valid) check("ready_while_busy", int'(tgt_ready), int'(n == n_total));
      end else begin
        check("done_quiet", int'(done), 0);
      end
    end
    check("co_count", n, lim);
    model_duty = ramp_expect(d0, t, s, d, n);
    tgt_valid  = 1'b0;
    if (n == n_total) begin
      tick();
      check("done_one_cycle", int'(done), 0);
      check("duty_hold", int'(duty), model_duty);
    end
  endtask

  // Tick until the DUT has seen one co, checking no done pulse meanwhile.
  task automatic wait_co();
    int cyc;
    cyc = 0;
    had_co = 1'b0;
    while (!had_co && cyc < 2 * M) begin
      tick();
      cyc++;
      check("done_absent", int'(done), 0);
    end
    check("co_seen", int'(had_co), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    tgt_valid = 1'b0;
    tgt_duty  = '0;
    step      = '0;
    div       = '0;
    co        = 1'b0;

    // Reset values and readiness.
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_ready_en0", int'(tgt_ready), 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("ready_en0", int'(tgt_ready), 0);
    en = 1'b1;
    #1;
    check("ready_en1", int'(tgt_ready), 1);

    // Upward ramp 0 -> 10 in steps of 3: 3, 6, 9, 10.
    start_request(10, 3, 0);
    follow(0, 10, 3, 0, 0);

    // Downward ramp 10 -> 2, step 4, one update every second period.
    start_request(2, 4, 1);
    follow(model_duty, 2, 4, 1, 0);

    // Jump to the top of the range with step 0 while a second request is held.
    // A 4-bit tgt_duty cannot carry 20, so the largest encodable value stands in.
    start_request(15, 0, 0);
    tgt_duty  = 4'd5;
    tgt_valid = 1'b1;
    follow(model_duty, 15, 0, 0, 0);
    check("no_accept_busy", int'(duty), 15);

    // Disable mid-ramp at duty 6 with step 3.
    start_request(0, 0, 0);
    follow(model_duty, 0, 0, 0, 0);
    start_request(12, 3, 0);
    follow(0, 12, 3, 0, 2);
    check("pre_disable_duty", int'(duty), 6);
    en = 1'b0;
    #1;
    check("ready_disabled", int'(tgt_ready), 0);
    tick();
`ifdef PWM_DUTY_SOFTSTOP_EN
    check("stop_busy", int'(busy), 1);
    wait_co();
    check("stop_duty_1", int'(duty), 3);
    check("stop_busy_1", int'(busy), 1);
    wait_co();
    check("stop_duty_2", int'(duty), 0);
    check("stop_busy_2", int'(busy), 0);
`else
    check("off_busy", int'(busy), 0);
    check("off_duty_held", int'(duty), 6);
    wait_co();
    check("off_duty", int'(duty), 0);
    check("off_busy_after", int'(busy), 0);
`endif
    model_duty = 0;
    tick();
    en = 1'b1;
    #1;

    // Asynchronous reset in the middle of a ramp.
    start_request(14, 2, 0);
    follow(0, 14, 2, 0, 2);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_duty", int'(duty), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_ready", int'(tgt_ready), 1);
    #2 rst_n = 1'b1;
    model_duty = 0;
    tick();
    start_request(7, 0, 0);
    follow(0, 7, 0, 0, 0);

    // Randomised requests from wherever the last one left the duty.
    for (int i = 0; i < 8; i++) begin
      int t;
      int s;
      int d;
      t = int'($urandom_range(0, 15));
      s = int'($urandom_range(0, 7));
      d = int'($urandom_range(0, 2));
      start_request(t, s, d);
      follow(model_duty, t, s, d, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
